// File: rtl/credit_event_driver_if.sv
// Bundle between upstream event clients and the credit event driver, plus the
// driver's outputs toward the incr/decr counter.
//   master : upstream side; offers return/take events and init requests and
//            observes ready and the counter-facing outputs.
//   slave  : the driver itself.
interface credit_event_driver_if #(
  parameter int unsigned VALUE_W = 4,
  parameter int unsigned STEP_W  = 2,
  parameter int unsigned AMT_W   = 3
);
  logic               ret_valid;
  logic [AMT_W-1:0]   ret_amt;
  logic               ret_ready;
  logic               take_valid;
  logic [AMT_W-1:0]   take_amt;
  logic               take_ready;
  logic               init_req;
  logic               init_drain;
  logic [VALUE_W-1:0] init_value;
  logic               incr_valid;
  logic [STEP_W-1:0]  incr;
  logic               decr_valid;
  logic [STEP_W-1:0]  decr;
  logic               reinit;
  logic [VALUE_W-1:0] initial_value;
  logic [VALUE_W-1:0] shadow_value;
  logic               busy;

  modport master (
    output ret_valid, ret_amt, take_valid, take_amt, init_req, init_drain, init_value,
    input  ret_ready, take_ready, incr_valid, incr, decr_valid, decr, reinit,
           initial_value, shadow_value, busy
  );

  modport slave (
    input  ret_valid, ret_amt, take_valid, take_amt, init_req, init_drain, init_value,
    output ret_ready, take_ready, incr_valid, incr, decr_valid, decr, reinit,
           initial_value, shadow_value, busy
  );
endinterface

// File: rtl/credit_event_driver.sv
// Producer-side driver for the incr/decr up/down counter.
// Buffers variable-size return (add) and take (subtract) events in pending
// accumulators and issues them as per-cycle steps of at most 2^STEP_W-1.
// Sequences counter reinit (immediate or after draining pending) and keeps a
// registered shadow of the counter value.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : credit_event_driver_if slave (events in, counter controls out)
module credit_event_driver #(
  parameter int unsigned VALUE_W     = 4,
  parameter int unsigned STEP_W      = 2,
  parameter int unsigned AMT_W       = 3,
  parameter int unsigned PEND_W      = 5,
  parameter int unsigned RESET_VALUE = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  credit_event_driver_if.slave bus
);

  localparam int unsigned PendMax  = (2 ** PEND_W) - 1;
  localparam int unsigned AmtMax   = (2 ** AMT_W) - 1;
  localparam int unsigned StepMax  = (2 ** STEP_W) - 1;
  // Highest occupancy at which a worst-case event still fits without overflow.
  localparam int unsigned AccLimit = PendMax - AmtMax;

  typedef enum logic [1:0] {StRun, StDrain, StInit} state_e;

  state_e             state_q;
  logic [PEND_W-1:0]  pend_inc_q, pend_dec_q;
  logic [PEND_W-1:0]  pend_inc_d, pend_dec_d;
  logic [VALUE_W-1:0] init_val_q;
  logic [VALUE_W-1:0] shadow_q, shadow_d;
  logic [STEP_W-1:0]  step_i, step_d;
  logic               issuing, ret_acc, take_acc, pend_empty_d;

  // Steps depend only on registered state, never on same-cycle inputs.
  always_comb begin
    issuing = (state_q != StInit);
    step_i  = '0;
    step_d  = '0;
    if (issuing) begin
      step_i = (pend_inc_q > PEND_W'(StepMax)) ? STEP_W'(StepMax) : pend_inc_q[STEP_W-1:0];
      step_d = (pend_dec_q > PEND_W'(StepMax)) ? STEP_W'(StepMax) : pend_dec_q[STEP_W-1:0];
    end
  end

  // Ready is forced low while reset is held, since state_q already reads StRun then.
  assign bus.ret_ready  = rst_n && (state_q == StRun) && (pend_inc_q <= PEND_W'(AccLimit));
  assign bus.take_ready = rst_n && (state_q == StRun) && (pend_dec_q <= PEND_W'(AccLimit));

  assign ret_acc  = bus.ret_valid & bus.ret_ready;
  assign take_acc = bus.take_valid & bus.take_ready;

  always_comb begin
    pend_inc_d   = pend_inc_q - PEND_W'(step_i) + (ret_acc ? PEND_W'(bus.ret_amt) : '0);
    pend_dec_d   = pend_dec_q - PEND_W'(step_d) + (take_acc ? PEND_W'(bus.take_amt) : '0);
    pend_empty_d = (pend_inc_d == '0) && (pend_dec_d == '0);
    // Modulo arithmetic: the shadow wraps exactly like the counter.
    shadow_d     = shadow_q + VALUE_W'(step_i) - VALUE_W'(step_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pend_inc_q <= '0;
      pend_dec_q <= '0;
      init_val_q <= VALUE_W'(RESET_VALUE);
      shadow_q   <= VALUE_W'(RESET_VALUE);
    end else begin
      unique case (state_q)
        StRun: begin
          pend_inc_q <= pend_inc_d;
          pend_dec_q <= pend_dec_d;
          shadow_q   <= shadow_d;
          if (bus.init_req) begin
            init_val_q <= bus.init_value;
            // Events accepted this same cycle are part of what gets drained.
            if (!bus.init_drain || pend_empty_d) begin
              state_q <= StInit;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          pend_inc_q <= pend_inc_d;
          pend_dec_q <= pend_dec_d;
          shadow_q   <= shadow_d;
          if (pend_empty_d) begin
            state_q <= StInit;
          end
        end
        StInit: begin
          pend_inc_q <= '0;
          pend_dec_q <= '0;
          shadow_q   <= init_val_q;
          state_q    <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.incr_valid    = (step_i != '0);
  assign bus.incr          = step_i;
  assign bus.decr_valid    = (step_d != '0);
  assign bus.decr          = step_d;
  assign bus.reinit        = (state_q == StInit);
  assign bus.initial_value = init_val_q;
  assign bus.shadow_value  = shadow_q;
  assign bus.busy          = (state_q != StRun);

endmodule
